spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 143 ++++++++++++++
 tb/tb_spi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter granting N_REQ requesters access to a
// single SPI master. A grant captures the requester's word, raises a write or
// read command until the master reports busy, then reports done (with the read
// word) or an error if the master never starts within START_TIMEOUT cycles.
module spi_arbiter #(
  parameter int N_REQ           = 4,
  parameter int MOSI_DATA_WIDTH = 8,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int START_TIMEOUT   = 255
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ-1:0]                   req_rd,
  input  logic [N_REQ*MOSI_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                   req_ack,
  output logic [N_REQ-1:0]                   req_done,
  output logic [N_REQ-1:0]                   req_err,
  output logic [MISO_DATA_WIDTH-1:0]         rd_data,
  output logic                               spi_wr_cmd,
  output logic                               spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]         mosi_data,
  input  logic                               spi_busy,
  input  logic [MISO_DATA_WIDTH-1:0]         miso_data
);

  localparam int unsigned NR       = N_REQ;
  localparam int          IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RUN,
    FIN
  } state_t;

  state_t                     state;
  logic [IDX_W-1:0]           ptr;
  logic [IDX_W-1:0]           gnt;
  logic                       rd_flag;
  logic [15:0]                cnt;

  logic [IDX_W-1:0]           cand;
  logic [IDX_W-1:0]           win_idx;
  logic                       win_vld;
  logic [MOSI_DATA_WIDTH-1:0] data_arr [N_REQ];

  // Split the flat request data bus into one word per requester
  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign data_arr[g] = req_data[g*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
  end

  // Round-robin pick: first valid requester at or after ptr, wrapping
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NR);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Transaction FSM; every output is a register, pulses clear by default
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      rd_flag    <= 1'b0;
      cnt        <= '0;
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      spi_wr_cmd <= 1'b0;
      spi_rd_cmd <= 1'b0;
      mosi_data  <= '0;
      rd_data    <= '0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        IDLE: begin
          spi_wr_cmd <= 1'b0;
          spi_rd_cmd <= 1'b0;
          cnt        <= '0;
          // a busy master in IDLE belongs to someone else: hold off granting
          if (win_vld && !spi_busy) begin
            gnt       <= win_idx;
            rd_flag   <= req_rd[win_idx];
            mosi_data <= data_arr[win_idx];
            req_ack   <= N_REQ'(1) << win_idx;
            ptr       <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            state     <= CMD;
          end
        end
        // Commands rise one cycle after the grant, so together with the
        // IDLE cycle the lines are low for at least two cycles even when a
        // timeout is followed directly by a new grant.
        CMD: begin
          if (spi_busy) begin
            spi_wr_cmd <= 1'b0;
            spi_rd_cmd <= 1'b0;
            cnt        <= '0;
            state      <= RUN;
          end else if (cnt == TO_LAST) begin
            spi_wr_cmd <= 1'b0;
            spi_rd_cmd <= 1'b0;
            cnt        <= '0;
            req_err    <= N_REQ'(1) << gnt;
            state      <= IDLE;
          end else begin
            spi_wr_cmd <= ~rd_flag;
            spi_rd_cmd <= rd_flag;
            cnt        <= cnt + 16'd1;
          end
        end
        RUN: begin
          spi_wr_cmd <= 1'b0;
          spi_rd_cmd <= 1'b0;
          if (!spi_busy) begin
            state <= FIN;
          end
        end
        FIN: begin
          if (rd_flag) begin
            rd_data <= miso_data;
          end
          req_done <= N_REQ'(1) << gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed and random transactions against a transaction-level
// reference model (round-robin order, timing of ack/done/err, command window,
// captured words) plus a simple SPI master model with random latencies.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 10;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_rd;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_done;
  logic [N-1:0]   req_err;
  logic [W-1:0]   rd_data;
  logic           spi_wr_cmd;
  logic           spi_rd_cmd;
  logic [W-1:0]   mosi_data;
  logic           spi_busy;
  logic [W-1:0]   miso_data;

  spi_arbiter #(
    .N_REQ(N),
    .MOSI_DATA_WIDTH(W),
    .MISO_DATA_WIDTH(W),
    .START_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .req_valid(req_valid),
    .req_rd(req_rd),
    .req_data(req_data),
    .req_ack(req_ack),
    .req_done(req_done),
    .req_err(req_err),
    .rd_data(rd_data),
    .spi_wr_cmd(spi_wr_cmd),
    .spi_rd_cmd(spi_rd_cmd),
    .mosi_data(mosi_data),
    .spi_busy(spi_busy),
    .miso_data(miso_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester models
  int         rem    [N];
  int         rd_cfg [N];   // 0 write, 1 read, 2 random
  bit         rd_q   [N];
  logic [W-1:0] data_q [N];

  // reference model state
  int         cyc;
  int         exp_ptr;
  logic [N-1:0] exp_ack;
  int         exp_idx;
  bit         exp_rdf;
  logic [W-1:0] exp_mosi_next;
  logic [W-1:0] cur_mosi;
  logic [W-1:0] exp_rd_data;
  bit         out_active;
  int         out_idx;
  bit         out_rd;
  int         ack_cyc, h_cyc, drop_cyc;
  int         order[$];
  int         done_cnt [N];
  int         err_cnt  [N];

  // SPI master model
  bit         mst_en;
  int         mst_phase, mst_cnt, mst_len_fix, mst_miso_fix;
  logic [W-1:0] mst_miso;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[IW'(i)] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[IW'((p + k) % N)]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = out_active || (exp_ack != '0) || (mst_phase != 0) || spi_busy;
    for (int i = 0; i < N; i++) if (rem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic add_req(input int i, input int n, input int rdc, input logic [W-1:0] d);
    rem[i]    = n;
    rd_cfg[i] = rdc;
    rd_q[i]   = (rdc == 2) ? 1'($urandom_range(0, 1)) : 1'(rdc);
    data_q[i] = d;
  endtask

  task automatic drive_master();
    if (!mst_en) return;
    if (mst_phase == 0 && (spi_wr_cmd || spi_rd_cmd)) begin
      mst_cnt   = $urandom_range(0, 3);
      mst_phase = 1;
    end
    if (mst_phase == 1) begin
      if (mst_cnt == 0) begin
        spi_busy  = 1'b1;
        h_cyc     = cyc;
        mst_cnt   = (mst_len_fix > 0) ? mst_len_fix : $urandom_range(1, 4);
        mst_phase = 2;
      end else begin
        mst_cnt--;
      end
    end else if (mst_phase == 2) begin
      mst_cnt--;
      if (mst_cnt == 0) begin
        spi_busy  = 1'b0;
        mst_miso  = (mst_miso_fix >= 0) ? W'(mst_miso_fix) : W'($urandom);
        miso_data = mst_miso;
        drop_cyc  = cyc;
        mst_phase = 0;
      end
    end
  endtask

  task automatic drive_requesters(input logic [N-1:0] ack);
    for (int i = 0; i < N; i++) begin
      if (ack[IW'(i)]) begin
        if (rem[i] > 0) rem[i]--;
        data_q[i] = W'($urandom);
        rd_q[i]   = (rd_cfg[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(rd_cfg[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[IW'(i)] = (rem[i] > 0);
      req_rd[IW'(i)]    = rd_q[i];
    end
    req_data = {data_q[3], data_q[2], data_q[1], data_q[0]};
  endtask

  task automatic predict();
    exp_ack = '0;
    if (nrst && !out_active && req_valid != '0 && !spi_busy) begin
      exp_idx       = rr_pick(req_valid, exp_ptr);
      exp_ack       = onehot(exp_idx);
      exp_rdf       = rd_q[exp_idx];
      exp_mosi_next = data_q[exp_idx];
      exp_ptr       = (exp_idx + 1) % N;
    end
  endtask

  // One clock: check this cycle's outputs, then drive and predict the next
  task automatic step();
    logic [N-1:0] exp_done, exp_err;
    bit cmd_on;
    @(negedge clk);
    cyc++;
    check_eq("ack", req_ack, exp_ack);
    if (exp_ack != '0) begin
      out_active = 1'b1;
      out_idx    = exp_idx;
      out_rd     = exp_rdf;
      ack_cyc    = cyc;
      h_cyc      = -1;
      drop_cyc   = -1;
      cur_mosi   = exp_mosi_next;
      order.push_back(exp_idx);
    end
    check_eq("mosi", mosi_data, cur_mosi);
    exp_done = '0;
    exp_err  = '0;
    if (out_active) begin
      if (!mst_en && cyc == ack_cyc + TO) exp_err = onehot(out_idx);
      if (drop_cyc >= 0 && cyc == drop_cyc + 2) exp_done = onehot(out_idx);
    end
    check_eq("done", req_done, exp_done);
    check_eq("err", req_err, exp_err);
    if (exp_done != '0) begin
      if (out_rd) exp_rd_data = mst_miso;
      done_cnt[out_idx]++;
      out_active = 1'b0;
    end
    if (exp_err != '0) begin
      err_cnt[out_idx]++;
      out_active = 1'b0;
    end
    check_eq("rd_data", rd_data, exp_rd_data);
    cmd_on = out_active && (cyc > ack_cyc) && (h_cyc < 0 || cyc <= h_cyc) && (cyc < ack_cyc + TO);
    check_eq("wr_cmd", spi_wr_cmd, cmd_on && !out_rd);
    check_eq("rd_cmd", spi_rd_cmd, cmd_on && out_rd);
    drive_master();
    drive_requesters(exp_ack);
    predict();
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (n < max_cyc && model_busy()) begin
      step();
      n++;
    end
    check_eq(tag, model_busy(), 0);
  endtask

  // Called right after a step: assert reset mid-cycle, release on a negedge
  task automatic do_reset(input int hold);
    #2 nrst = 1'b0;
    #1;
    check_eq("rst_ack", req_ack, 0);
    check_eq("rst_done", req_done, 0);
    check_eq("rst_err", req_err, 0);
    check_eq("rst_wr", spi_wr_cmd, 0);
    check_eq("rst_rd", spi_rd_cmd, 0);
    check_eq("rst_mosi", mosi_data, 0);
    check_eq("rst_rdd", rd_data, 0);
    out_active  = 1'b0;
    exp_ack     = '0;
    exp_ptr     = 0;
    cur_mosi    = '0;
    exp_rd_data = '0;
    mst_phase   = 0;
    spi_busy    = 1'b0;
    h_cyc       = -1;
    drop_cyc    = -1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    cyc++;
    nrst = 1'b1;
    drive_requesters('0);
    predict();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, i;
    nrst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    spi_busy = 1'b0; miso_data = '0; mst_miso = '0;
    cyc = 0; exp_ptr = 0; exp_ack = '0; exp_idx = 0; exp_rdf = 1'b0;
    exp_mosi_next = '0; cur_mosi = '0; exp_rd_data = '0; out_active = 1'b0;
    out_idx = 0; out_rd = 1'b0; ack_cyc = 0; h_cyc = -1; drop_cyc = -1;
    mst_en = 1'b1; mst_phase = 0; mst_cnt = 0; mst_len_fix = 0; mst_miso_fix = -1;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0; rd_cfg[k] = 0; rd_q[k] = 1'b0; data_q[k] = '0;
      done_cnt[k] = 0; err_cnt[k] = 0;
    end
    do_reset(3);
    repeat (2) step();

    // single write from requester 0
    add_req(0, 1, 0, 8'hA5);
    run_until_idle(60, "p1_idle");
    check_eq("p1_mosi", mosi_data, 8'hA5);
    check_eq("p1_done", done_cnt[0], 1);

    // read from requester 2 returning 0x3C
    mst_miso_fix = 8'h3C;
    add_req(2, 1, 1, 8'h17);
    run_until_idle(60, "p2_idle");
    check_eq("p2_rd_data", rd_data, 8'h3C);
    check_eq("p2_done", done_cnt[2], 1);
    mst_miso_fix = -1;

    // foreign busy while idle holds off requester 3
    mst_en   = 1'b0;
    spi_busy = 1'b1;
    add_req(3, 1, 0, 8'h66);
    repeat (6) step();
    check_eq("p3_no_grant", order.size(), 2);
    spi_busy = 1'b0;
    predict();
    mst_en = 1'b1;
    run_until_idle(60, "p3_idle");
    check_eq("p3_gnt", order[order.size()-1], 3);
    check_eq("p3_done", done_cnt[3], 1);

    // fairness: all four held for two transactions each
    order.delete();
    for (int k = 0; k < N; k++) add_req(k, 2, 2, W'($urandom));
    run_until_idle(300, "p4_idle");
    check_eq("p4_count", order.size(), 8);
    for (int k = 0; k < 8; k++) begin
      d0 = (k < order.size()) ? order[k] : -1;
      check_eq($sformatf("p4_order%0d", k), d0, k % 4);
    end

    // start timeout on requester 1, then a normal transaction from it
    mst_en = 1'b0;
    add_req(1, 1, 1, 8'h99);
    run_until_idle(60, "p5_idle");
    check_eq("p5_err", err_cnt[1], 1);
    mst_en = 1'b1;
    add_req(1, 1, 0, 8'h42);
    run_until_idle(60, "p5b_idle");
    check_eq("p5b_done", done_cnt[1], 3);
    check_eq("p5b_err", err_cnt[1], 1);

    // reset in the middle of a busy transaction
    mst_len_fix = 8;
    add_req(2, 1, 1, 8'h5A);
    d0 = 0;
    while (d0 < 30 && !spi_busy) begin step(); d0++; end
    check_eq("p6_busy_seen", spi_busy, 1);
    repeat (2) step();
    order.delete();
    add_req(3, 1, 0, 8'h33);
    add_req(0, 1, 0, 8'h11);
    d0 = done_cnt[2];
    do_reset(3);
    mst_len_fix = 0;
    run_until_idle(100, "p6_idle");
    check_eq("p6_first", (order.size() > 0) ? order[0] : -1, 0);
    check_eq("p6_no_done", done_cnt[2], d0);

    // random traffic with mixed directions and occasional withdrawn requests
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(0, N - 1);
        if (rem[i] == 0) add_req(i, 1, 2, W'($urandom));
        else if (rem[i] < 3) rem[i]++;
      end
      if ($urandom_range(0, 29) == 0) rem[$urandom_range(0, N - 1)] = 0;
      step();
    end
    run_until_idle(400, "rnd_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
